// File: rtl/operand_stack.sv
// Operand stack for the stack-machine ALU path. It supports direct push and pop, and a
// one- or two-operand fetch into registered A/B operands followed by an ALU result write-back.
module operand_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     fetch2,
  input  logic                     fetch1,
  input  logic                     wb,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     err_clr,
  output logic [DATA_W-1:0]        a_out,
  output logic [DATA_W-1:0]        b_out,
  output logic                     opnd_valid,
  output logic [DATA_W-1:0]        tos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     busy,
  output logic                     err
);

  // state  | meaning
  // IDLE   | accepts push / pop / fetch1 / fetch2
  // POP_B  | top entry moves into b_out
  // POP_A  | top entry moves into a_out
  // READY  | operands are valid and the block waits for wb

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, POP_B, POP_A, READY} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       top_idx;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                err_set;

  // When the stack is full, the low bits of count wrap to 0, so top_idx still lands on DEPTH-1.
  assign top_idx = count[AW-1:0] - AW'(1);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign tos     = empty ? '0 : mem[top_idx];

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = count[AW-1:0];
    mem_wdata = push_data;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (fetch2) begin
          err_set = (count < CW'(2));
        end else if (fetch1) begin
          err_set = empty;
        end else if (push && pop) begin
          if (empty) begin
            err_set = 1'b1;
          end else begin
            mem_we   = 1'b1;
            mem_addr = top_idx;
          end
        end else if (push) begin
          if (full) err_set = 1'b1;
          else      mem_we  = 1'b1;
        end else if (pop) begin
          err_set = empty;
        end
      end
      READY: begin
        if (wb) begin
          mem_we    = 1'b1;
          mem_wdata = wb_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      a_out      <= '0;
      b_out      <= '0;
      opnd_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          if (fetch2) begin
            if (!err_set) state <= POP_B;
          end else if (fetch1) begin
            if (!err_set) begin
              state <= POP_A;
              b_out <= '0;
            end
          end else if (push && !pop) begin
            if (!full) count <= count + CW'(1);
          end else if (pop && !push) begin
            if (!empty) count <= count - CW'(1);
          end
        end
        POP_B: begin
          b_out <= tos;
          count <= count - CW'(1);
          state <= POP_A;
        end
        POP_A: begin
          a_out      <= tos;
          count      <= count - CW'(1);
          opnd_valid <= 1'b1;
          state      <= READY;
        end
        READY: begin
          if (wb) begin
            count      <= count + CW'(1);
            opnd_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack. It applies table vectors and directed corner sequences,
// then random traffic, and compares every cycle against a queue-based reference model.
module tb_operand_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, fetch2, fetch1, wb, err_clr;
  logic [7:0]  push_data, wb_data;
  logic [7:0]  a_out, b_out, tos;
  logic [4:0]  count;
  logic        opnd_valid, full, empty, busy, err;

  int checks = 0;
  int errors = 0;

  operand_stack #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .fetch2(fetch2), .fetch1(fetch1), .wb(wb), .wb_data(wb_data), .err_clr(err_clr),
    .a_out(a_out), .b_out(b_out), .opnd_valid(opnd_valid), .tos(tos), .count(count),
    .full(full), .empty(empty), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: the queue holds the stack contents, bottom first.
  logic [7:0] mq[$];
  int         m_pops;
  bit         m_ready;
  logic [7:0] m_a, m_b;
  bit         m_err;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pops = 0; m_ready = 0; m_a = 0; m_b = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit set;
    set = 0;
    if (m_pops > 0) begin
      if (m_pops == 2) m_b = mq.pop_back();
      else             m_a = mq.pop_back();
      m_pops--;
      if (m_pops == 0) m_ready = 1;
    end else if (m_ready) begin
      if (wb) begin
        mq.push_back(wb_data);
        m_ready = 0;
      end
    end else begin
      if (fetch2) begin
        if (mq.size() >= 2) m_pops = 2; else set = 1;
      end else if (fetch1) begin
        if (mq.size() >= 1) begin m_pops = 1; m_b = 0; end else set = 1;
      end else if (push && pop) begin
        if (mq.size() == 0) set = 1; else mq[mq.size()-1] = push_data;
      end else if (push) begin
        if (mq.size() == 16) set = 1; else mq.push_back(push_data);
      end else if (pop) begin
        if (mq.size() == 0) set = 1; else void'(mq.pop_back());
      end
    end
    if (set) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic model_check();
    chk("m_count", int'(count), mq.size());
    chk("m_tos", int'(tos), (mq.size() > 0) ? int'(mq[mq.size()-1]) : 0);
    chk("m_a_out", int'(a_out), int'(m_a));
    chk("m_b_out", int'(b_out), int'(m_b));
    chk("m_opnd_valid", int'(opnd_valid), int'(m_ready));
    chk("m_busy", int'(busy), int'(m_ready || m_pops > 0));
    chk("m_full", int'(full), int'(mq.size() == 16));
    chk("m_empty", int'(empty), int'(mq.size() == 0));
    chk("m_err", int'(err), int'(m_err));
  endtask

  task automatic step(input logic p, input logic [7:0] pd, input logic po, input logic f2,
                      input logic f1, input logic w, input logic [7:0] wd, input logic ec);
    push = p; push_data = pd; pop = po; fetch2 = f2; fetch1 = f1;
    wb = w; wb_data = wd; err_clr = ec;
    @(posedge clk);
    #1;
    model_edge();
    model_check();
  endtask

  task automatic nop();
    step(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_opnd_valid", int'(opnd_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(empty), 1);
    model_reset();
    model_check();
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       p;  logic [7:0] pd; logic po; logic f2; logic f1;
    logic       w;  logic [7:0] wd; logic ec;
    int cnt; int tos; int a; int b; bit v; bit bsy; bit er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic p, input logic [7:0] pd, input logic po, input logic f2,
                     input logic f1, input logic w, input logic [7:0] wd, input logic ec,
                     input int cnt, input int t, input int a, input int b,
                     input bit v, input bit bsy, input bit er);
    vec_t x;
    x.p = p; x.pd = pd; x.po = po; x.f2 = f2; x.f1 = f1; x.w = w; x.wd = wd; x.ec = ec;
    x.cnt = cnt; x.tos = t; x.a = a; x.b = b; x.v = v; x.bsy = bsy; x.er = er;
    tbl.push_back(x);
  endtask

  initial begin
    // push pd pop f2 f1 wb wd ec | cnt tos a b valid busy err
    add(1,8'h05,0,0,0,0,8'h00,0,  1,8'h05,8'h00,8'h00,0,0,0);
    add(1,8'h03,0,0,0,0,8'h00,0,  2,8'h03,8'h00,8'h00,0,0,0);
    add(0,8'h00,0,1,0,0,8'h00,0,  2,8'h03,8'h00,8'h00,0,1,0);
    add(0,8'h00,0,0,0,0,8'h00,0,  1,8'h05,8'h00,8'h03,0,1,0);
    add(0,8'h00,0,0,0,0,8'h00,0,  0,8'h00,8'h05,8'h03,1,1,0);
    add(0,8'h00,0,0,0,1,8'h02,0,  1,8'h02,8'h05,8'h03,0,0,0);
    add(1,8'hA5,0,0,0,0,8'h00,0,  2,8'hA5,8'h05,8'h03,0,0,0);
    add(0,8'h00,0,0,1,0,8'h00,0,  2,8'hA5,8'h05,8'h00,0,1,0);
    add(0,8'h00,0,0,0,0,8'h00,0,  1,8'h02,8'hA5,8'h00,1,1,0);
    add(0,8'h00,0,0,0,1,8'h5A,0,  2,8'h5A,8'hA5,8'h00,0,0,0);
    add(0,8'h00,1,0,0,0,8'h00,0,  1,8'h02,8'hA5,8'h00,0,0,0);
    add(0,8'h00,1,0,0,0,8'h00,0,  0,8'h00,8'hA5,8'h00,0,0,0);
    add(0,8'h00,1,0,0,0,8'h00,0,  0,8'h00,8'hA5,8'h00,0,0,1);
    add(1,8'h11,0,0,0,0,8'h00,0,  1,8'h11,8'hA5,8'h00,0,0,1);
    add(0,8'h00,0,1,0,0,8'h00,0,  1,8'h11,8'hA5,8'h00,0,0,1);
    add(0,8'h00,0,0,0,0,8'h00,1,  1,8'h11,8'hA5,8'h00,0,0,0);
    add(0,8'h00,1,0,0,0,8'h00,0,  0,8'h00,8'hA5,8'h00,0,0,0);
    add(0,8'h00,1,0,0,0,8'h00,1,  0,8'h00,8'hA5,8'h00,0,0,1);
    add(0,8'h00,0,0,0,0,8'h00,1,  0,8'h00,8'hA5,8'h00,0,0,0);
    add(1,8'h33,1,0,0,0,8'h00,0,  0,8'h00,8'hA5,8'h00,0,0,1);
    add(0,8'h00,0,0,0,0,8'h00,1,  0,8'h00,8'hA5,8'h00,0,0,0);
    add(0,8'h00,0,0,1,0,8'h00,0,  0,8'h00,8'hA5,8'h00,0,0,1);
    add(1,8'h44,0,0,0,0,8'h00,1,  1,8'h44,8'hA5,8'h00,0,0,0);
    add(1,8'h55,0,0,1,0,8'h00,0,  1,8'h44,8'hA5,8'h00,0,1,0);
    add(0,8'h00,0,0,0,0,8'h00,0,  0,8'h00,8'h44,8'h00,1,1,0);
    add(1,8'h77,0,0,0,1,8'h66,0,  1,8'h66,8'h44,8'h00,0,0,0);
    add(0,8'h00,0,0,0,1,8'h99,0,  1,8'h66,8'h44,8'h00,0,0,0);

    rst = 1'b1;
    push = 0; pop = 0; fetch2 = 0; fetch1 = 0; wb = 0; err_clr = 0;
    push_data = 0; wb_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'({count, a_out, b_out, opnd_valid, err, busy, empty}),
        int'({5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].p, tbl[i].pd, tbl[i].po, tbl[i].f2, tbl[i].f1, tbl[i].w, tbl[i].wd, tbl[i].ec);
      chk($sformatf("vec%0d_count", i), int'(count), tbl[i].cnt);
      chk($sformatf("vec%0d_tos", i), int'(tos), tbl[i].tos);
      chk($sformatf("vec%0d_a", i), int'(a_out), tbl[i].a);
      chk($sformatf("vec%0d_b", i), int'(b_out), tbl[i].b);
      chk($sformatf("vec%0d_valid", i), int'(opnd_valid), int'(tbl[i].v));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].bsy));
      chk($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].er));
    end

    // Fill, overflow and the full-stack replace.
    step(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
    chk("drain_empty", int'(empty), 1);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0, 8'h00, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_tos", int'(tos), 8'h0F);
    step(1, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
    chk("ovf_err", int'(err), 1);
    chk("ovf_tos", int'(tos), 8'h0F);
    chk("ovf_count", int'(count), 16);
    step(1, 8'h77, 1, 0, 0, 0, 8'h00, 0);
    chk("repl_tos", int'(tos), 8'h77);
    chk("repl_count", int'(count), 16);
    step(0, 8'h00, 0, 0, 0, 0, 8'h00, 1);
    chk("clr_err", int'(err), 0);

    // Commands during a fetch are ignored, then async reset in READY.
    step(0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
    step(1, 8'hAA, 1, 0, 0, 0, 8'h00, 0);
    chk("popb_b", int'(b_out), 8'h77);
    chk("popb_count", int'(count), 15);
    chk("popb_err", int'(err), 0);
    step(1, 8'hBB, 1, 1, 0, 0, 8'h00, 0);
    chk("popa_a", int'(a_out), 8'h0E);
    chk("popa_valid", int'(opnd_valid), 1);
    step(1, 8'hCC, 1, 1, 1, 0, 8'h00, 0);
    chk("ready_hold_a", int'(a_out), 8'h0E);
    chk("ready_hold_b", int'(b_out), 8'h77);
    chk("ready_count", int'(count), 14);
    chk("ready_err", int'(err), 0);
    async_reset();

    // fetch2 beats push in the same cycle.
    step(1, 8'h01, 0, 0, 0, 0, 8'h00, 0);
    step(1, 8'h02, 0, 0, 0, 0, 8'h00, 0);
    step(1, 8'h03, 0, 0, 0, 0, 8'h00, 0);
    step(1, 8'hEE, 0, 1, 0, 0, 8'h00, 0);
    chk("f2push_count", int'(count), 3);
    nop();
    nop();
    chk("f2push_after", int'(count), 1);
    chk("f2push_tos", int'(tos), 8'h01);
    chk("f2push_a", int'(a_out), 8'h02);
    chk("f2push_b", int'(b_out), 8'h03);
    step(0, 8'h00, 0, 0, 0, 1, 8'h05, 0);
    chk("f2push_wb", int'(tos), 8'h05);
    step(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
    chk("f2push_no_ee", int'(tos), 8'h01);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 99) < 35,
             $urandom_range(0, 11) == 0, $urandom_range(0, 13) == 0,
             $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 11) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
